// File: rtl/ofdm_symbol_framer.sv
// ofdm_symbol_framer: cuts FFT windows out of the sample stream after a detector trigger,
// skipping a start offset and the cyclic prefix between symbols.
module ofdm_symbol_framer #(
  parameter int WIDTH   = 32,
  parameter int SR_BASE = 130,
  parameter int CNT_W   = 16
) (
  input  logic             ce_clk,
  input  logic             ce_rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_ttrig,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic             missed_trig,
  output logic [CNT_W-1:0] frame_idx
);
  typedef enum logic [1:0] {IDLE, OFFSET, FRAME, GAP} state_t;
  localparam logic [7:0] A_FLEN = 8'(SR_BASE);
  localparam logic [7:0] A_GAP  = 8'(SR_BASE + 1);
  localparam logic [7:0] A_OFF  = 8'(SR_BASE + 2);
  localparam logic [7:0] A_MAX  = 8'(SR_BASE + 3);
  state_t state, st_nx;
  logic [CNT_W-1:0] frame_len, gap_len, offset, max_frames;
  logic [CNT_W-1:0] s_flen, s_gap, s_off, s_max, cnt;
  logic [CNT_W-1:0] e_flen, e_gap, e_off, e_max, cnt_nx, idx_nx;
  logic beat, start, in_off, in_frame, in_gap, active, hit, done;
  logic unused_bits;
  assign unused_bits = ^{i_tlast, set_data};
  assign i_tready = !o_tvalid || o_tready;
  assign busy = state != IDLE;
  // On the trigger beat the live settings act as the shadows, so that beat is framed like any other.
  always_comb begin
    beat     = i_tvalid && i_tready;
    start    = beat && i_ttrig && state == IDLE;
    e_flen   = start ? (frame_len == '0 ? CNT_W'(1) : frame_len) : s_flen;
    e_gap    = start ? gap_len : s_gap;
    e_off    = start ? offset : s_off;
    e_max    = start ? max_frames : s_max;
    cnt_nx   = (start ? '0 : cnt) + CNT_W'(1);
    in_off   = start ? e_off != '0 : state == OFFSET;
    in_frame = start ? e_off == '0 : state == FRAME;
    in_gap   = state == GAP;
    active   = in_off || in_frame || in_gap;
    hit      = cnt_nx == (in_off ? e_off : in_frame ? e_flen : e_gap);
    idx_nx   = frame_idx + CNT_W'(1);
    done     = in_frame && hit && e_max != '0 && idx_nx == e_max;
    st_nx    = !hit ? (in_off ? OFFSET : in_frame ? FRAME : GAP) :
               !in_frame ? FRAME : done ? IDLE : e_gap != '0 ? GAP : FRAME;
  end
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      frame_len   <= CNT_W'(64);
      gap_len     <= CNT_W'(16);
      offset      <= '0;
      max_frames  <= '0;
      s_flen      <= CNT_W'(1);
      s_gap       <= '0;
      s_off       <= '0;
      s_max       <= '0;
      cnt         <= '0;
      state       <= IDLE;
      frame_idx   <= '0;
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      missed_trig <= 1'b0;
    end else begin
      if (set_stb && set_addr == A_FLEN) frame_len <= set_data[CNT_W-1:0];
      if (set_stb && set_addr == A_GAP) gap_len <= set_data[CNT_W-1:0];
      if (set_stb && set_addr == A_OFF) offset <= set_data[CNT_W-1:0];
      if (set_stb && set_addr == A_MAX) max_frames <= set_data[CNT_W-1:0];
      if (start) begin
        s_flen <= e_flen;
        s_gap  <= e_gap;
        s_off  <= e_off;
        s_max  <= e_max;
      end
      if (beat && active) begin
        state <= st_nx;
        cnt   <= hit ? '0 : cnt_nx;
      end
      if (beat && in_frame && hit) frame_idx <= done ? '0 : idx_nx;
      if (beat && in_frame) begin
        o_tvalid <= 1'b1;
        o_tdata  <= i_tdata;
        o_tlast  <= hit;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
        o_tlast  <= 1'b0;
      end
      missed_trig <= beat && i_ttrig && state != IDLE;
    end
  end
endmodule
